bus_controller: RTL and testbench
=================================

BUS_CONTROLLER -- requirements
Module: bus_controller

Interface
REQ-001 The module SHALL have parameter ROM_WS, default 1, meaning ROM wait cycles (0-15).
REQ-002 The module SHALL have parameter RAM_WS, default 2, meaning RAM wait cycles (0-15).
REQ-003 The module SHALL have parameter GFX_WS, default 1, meaning graphics wait cycles (0-15).
REQ-004 The module SHALL have parameter IO_TIMEOUT, default 16, meaning the maximum IO wait cycles before a bus error (1-255).
REQ-005 The module SHALL have one clock and an asynchronous, active-high reset: clk in 1 (rising edge), reset in 1.
REQ-006 Requester ports SHALL be: cpu_req in 1; cpu_addr in 32; cpu_we in 1; cpu_be in 4; cpu_wdata in 32.
REQ-007 Requester response ports SHALL be: cpu_ready out 1 (response pulse); cpu_rdata out 32; cpu_err out 1.
REQ-008 Slave select ports SHALL be: rom_sel, ram_sel, io_sel, gfx_sel, each out 1, active-high.
REQ-009 Shared slave bus ports SHALL be: bus_addr out 32; bus_we out 1; bus_be out 4; bus_wdata out 32.
REQ-010 Slave return ports SHALL be: rom_rdata, ram_rdata, io_rdata, gfx_rdata, each in 32; io_ack in 1.

Function
REQ-011 Region decode SHALL be, inclusive: ROM 0x00000000-0x00007FFF; IO 0x00400000-0x0040FFFF; GFX 0x04010000-0x0401000F; RAM 0x08000000-0x0BFFFFFF; any other address is unmapped.
REQ-012 The FSM SHALL have states IDLE, WAIT, IO_WAIT and RESP; reset state is IDLE.
REQ-013 In IDLE with cpu_req=1, the block SHALL latch addr/we/be/wdata into bus_* and decode the region at that edge.
REQ-014 On acceptance, a ROM/RAM/GFX access SHALL go to WAIT with the wait counter loaded with that region's WS.
REQ-015 On acceptance, an IO access SHALL go to IO_WAIT with the wait counter loaded with IO_TIMEOUT-1.
REQ-016 On acceptance, an unmapped access SHALL go directly to RESP with cpu_err=1, assert no select, and drive cpu_rdata=0.
REQ-017 The select of the decoded region SHALL be high in every WAIT/IO_WAIT cycle, low in all other states, with at most one select high at any time.
REQ-018 In WAIT, when counter==0, the block SHALL capture the selected rdata (reads) or 0 (writes) and go to RESP; otherwise it SHALL decrement the counter.
REQ-019 A ROM/RAM/GFX access SHALL therefore hold its select for WS+1 cycles, and cpu_ready SHALL rise WS+2 cycles after the accepting edge.
REQ-020 In IO_WAIT with io_ack=1, the block SHALL capture io_rdata (reads) or 0 (writes) and go to RESP with cpu_err=0.
REQ-021 In IO_WAIT with io_ack=0 and counter==0, the block SHALL go to RESP with cpu_err=1 and cpu_rdata=0; otherwise it SHALL decrement the counter.
REQ-022 If io_ack=1 arrives in the same cycle the counter reaches 0, the ack SHALL take priority and the access completes without error.
REQ-023 RESP SHALL last exactly one cycle with cpu_ready=1, then go to IDLE.
REQ-024 cpu_rdata and cpu_err SHALL be valid only while cpu_ready=1 and SHALL hold their values until the next RESP.
REQ-025 cpu_req SHALL be ignored outside IDLE; the next request SHALL be accepted no earlier than the first IDLE cycle after RESP.
REQ-026 ROM writes SHALL complete normally with no error, as do writes to any other mapped region.
REQ-027 bus_addr, bus_we, bus_be and bus_wdata SHALL remain stable from acceptance through RESP.

Reset
REQ-028 On reset assertion, state SHALL go to IDLE immediately and asynchronously.
REQ-029 On reset assertion, every select, cpu_ready and cpu_err SHALL go to 0, and cpu_rdata, bus_* and the counter SHALL go to 0.
REQ-030 Reset asserted mid-access SHALL abort the access with no cpu_ready pulse.
REQ-031 The first request after reset deassertion SHALL be accepted on the first rising edge with reset=0 and cpu_req=1.

Verification
REQ-032 The bench SHALL check a RAM read of 0x08000010 with ram_rdata=0xDEADBEEF (RAM_WS=2): ram_sel high 3 cycles, cpu_ready 4 cycles after acceptance, cpu_rdata=0xDEADBEEF, cpu_err=0.
REQ-033 The bench SHALL check an IO write to 0x00400004 with io_ack asserted in the 3rd IO_WAIT cycle: io_sel high 3 cycles, then cpu_ready with cpu_err=0.
REQ-034 The bench SHALL check an IO read with io_ack held 0 (IO_TIMEOUT=16): io_sel high 16 cycles, then cpu_ready with cpu_err=1 and cpu_rdata=0.
REQ-035 The bench SHALL check an unmapped read of 0x00008000: no select, cpu_ready on the next cycle, cpu_err=1.
REQ-036 The bench SHALL check decode boundaries at 0x00007FFF, 0x0401000F, 0x04010010, 0x0BFFFFFF and 0x0C000000: ROM, GFX, err, RAM, err respectively.
REQ-037 The bench SHALL check reset asserted during the 2nd WAIT cycle of a RAM read: ram_sel drops immediately, no cpu_ready, and a following ROM read (ROM_WS=1) completes 3 cycles after acceptance.

Source files
------------

// File: rtl/bus_controller.sv
// bus_controller: single-master bus bridge with address decode and per-region wait states.
//
// A CPU request is accepted in IDLE. Its address and write data are latched onto the shared
// slave bus, and the address is decoded to ROM, RAM, IO or GFX. A decoded region's select stays
// high for the programmed wait states. IO instead waits for io_ack, bounded by IO_TIMEOUT.
// Every access, including one to an unmapped address, ends with a one-cycle cpu_ready pulse.
// cpu_rdata and cpu_err are valid during that pulse.
//
// Ports:
//   clk, reset                      clock, asynchronous active-high reset
//   cpu_req/addr/we/be/wdata        requester command
//   cpu_ready/rdata/err             requester response (ready is a single-cycle pulse)
//   rom_sel/ram_sel/io_sel/gfx_sel  one-hot slave selects
//   bus_addr/we/be/wdata            shared slave bus, stable from acceptance through RESP
//   rom/ram/io/gfx_rdata, io_ack    slave returns

module bus_controller #(
    parameter int unsigned ROM_WS     = 1,
    parameter int unsigned RAM_WS     = 2,
    parameter int unsigned GFX_WS     = 1,
    parameter int unsigned IO_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic [31:0] cpu_addr,
    input  logic        cpu_we,
    input  logic [3:0]  cpu_be,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_ready,
    output logic [31:0] cpu_rdata,
    output logic        cpu_err,
    output logic        rom_sel,
    output logic        ram_sel,
    output logic        io_sel,
    output logic        gfx_sel,
    output logic [31:0] bus_addr,
    output logic        bus_we,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic [31:0] rom_rdata,
    input  logic [31:0] ram_rdata,
    input  logic [31:0] io_rdata,
    input  logic [31:0] gfx_rdata,
    input  logic        io_ack
);

    typedef enum logic [1:0] {StIdle, StWait, StIoWait, StResp} state_e;
    typedef enum logic [2:0] {RgNone, RgRom, RgRam, RgIo, RgGfx} region_e;

    state_e      state_q, state_d;
    region_e     region_q, region_d, dec_region;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
    logic        we_q, we_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] slave_rdata;
    logic        active;

    // Address decode of the incoming request.
    always_comb begin
        dec_region = RgNone;
        if (cpu_addr[31:15] == 17'h0) begin
            dec_region = RgRom;
        end else if (cpu_addr[31:16] == 16'h0040) begin
            dec_region = RgIo;
        end else if (cpu_addr[31:4] == 28'h0401000) begin
            dec_region = RgGfx;
        end else if (cpu_addr[31:26] == 6'h02) begin
            dec_region = RgRam;
        end
    end

    // Read data of the region latched at acceptance.
    always_comb begin
        case (region_q)
            RgRom:   slave_rdata = rom_rdata;
            RgRam:   slave_rdata = ram_rdata;
            RgGfx:   slave_rdata = gfx_rdata;
            default: slave_rdata = 32'h0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        region_d = region_q;
        cnt_d    = cnt_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        addr_d   = addr_q;
        we_d     = we_q;
        be_d     = be_q;
        wdata_d  = wdata_q;
        case (state_q)
            StIdle: begin
                if (cpu_req) begin
                    addr_d   = cpu_addr;
                    we_d     = cpu_we;
                    be_d     = cpu_be;
                    wdata_d  = cpu_wdata;
                    region_d = dec_region;
                    case (dec_region)
                        RgRom: begin
                            state_d = StWait;
                            cnt_d   = 8'(ROM_WS);
                        end
                        RgRam: begin
                            state_d = StWait;
                            cnt_d   = 8'(RAM_WS);
                        end
                        RgGfx: begin
                            state_d = StWait;
                            cnt_d   = 8'(GFX_WS);
                        end
                        RgIo: begin
                            state_d = StIoWait;
                            cnt_d   = 8'(IO_TIMEOUT - 1);
                        end
                        default: begin
                            state_d = StResp;
                            rdata_d = 32'h0;
                            err_d   = 1'b1;
                        end
                    endcase
                end
            end
            StWait: begin
                if (cnt_q == 8'h0) begin
                    state_d = StResp;
                    rdata_d = we_q ? 32'h0 : slave_rdata;
                    err_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q - 8'h1;
                end
            end
            StIoWait: begin
                // Ack wins over a timeout that expires in the same cycle.
                if (io_ack) begin
                    state_d = StResp;
                    rdata_d = we_q ? 32'h0 : io_rdata;
                    err_d   = 1'b0;
                end else if (cnt_q == 8'h0) begin
                    state_d = StResp;
                    rdata_d = 32'h0;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q - 8'h1;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            region_q <= RgNone;
            cnt_q    <= 8'h0;
            rdata_q  <= 32'h0;
            err_q    <= 1'b0;
            addr_q   <= 32'h0;
            we_q     <= 1'b0;
            be_q     <= 4'h0;
            wdata_q  <= 32'h0;
        end else begin
            state_q  <= state_d;
            region_q <= region_d;
            cnt_q    <= cnt_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
            be_q     <= be_d;
            wdata_q  <= wdata_d;
        end
    end

    // Selects are decoded from registered state, so reset drops them immediately.
    assign active    = (state_q == StWait) || (state_q == StIoWait);
    assign rom_sel   = active && (region_q == RgRom);
    assign ram_sel   = active && (region_q == RgRam);
    assign io_sel    = active && (region_q == RgIo);
    assign gfx_sel   = active && (region_q == RgGfx);
    assign cpu_ready = (state_q == StResp);
    assign cpu_rdata = rdata_q;
    assign cpu_err   = err_q;
    assign bus_addr  = addr_q;
    assign bus_we    = we_q;
    assign bus_be    = be_q;
    assign bus_wdata = wdata_q;

endmodule

// File: tb/tb_bus_controller.sv
// Directed bench for bus_controller with default parameters
// (ROM_WS=1, RAM_WS=2, GFX_WS=1, IO_TIMEOUT=16).
module tb_bus_controller;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cpu_req = 1'b0;
    logic [31:0] cpu_addr = 32'h0;
    logic        cpu_we = 1'b0;
    logic [3:0]  cpu_be = 4'h0;
    logic [31:0] cpu_wdata = 32'h0;
    logic        cpu_ready, cpu_err;
    logic [31:0] cpu_rdata;
    logic        rom_sel, ram_sel, io_sel, gfx_sel;
    logic [31:0] bus_addr, bus_wdata;
    logic        bus_we;
    logic [3:0]  bus_be;
    logic [31:0] rom_rdata = 32'h1111AAAA;
    logic [31:0] ram_rdata = 32'hDEADBEEF;
    logic [31:0] io_rdata = 32'h10C0FFEE;
    logic [31:0] gfx_rdata = 32'h6F600D00;
    logic        io_ack = 1'b0;

    int n_cmp = 0;
    int n_fail = 0;

    bus_controller dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_req   (cpu_req),
        .cpu_addr  (cpu_addr),
        .cpu_we    (cpu_we),
        .cpu_be    (cpu_be),
        .cpu_wdata (cpu_wdata),
        .cpu_ready (cpu_ready),
        .cpu_rdata (cpu_rdata),
        .cpu_err   (cpu_err),
        .rom_sel   (rom_sel),
        .ram_sel   (ram_sel),
        .io_sel    (io_sel),
        .gfx_sel   (gfx_sel),
        .bus_addr  (bus_addr),
        .bus_we    (bus_we),
        .bus_be    (bus_be),
        .bus_wdata (bus_wdata),
        .rom_rdata (rom_rdata),
        .ram_rdata (ram_rdata),
        .io_rdata  (io_rdata),
        .gfx_rdata (gfx_rdata),
        .io_ack    (io_ack)
    );

    always #5 clk = ~clk;

    // Issues one request and observes it until cpu_ready. Latency counts sampled cycles after
    // the accepting edge (the first cycle after that edge is 1); -1 means no response came.
    // io_ack is driven high during cycle ack_cyc only (0 = never).
    task automatic do_access(input logic [31:0] addr, input logic we, input int ack_cyc,
                             output int lat, output int n_rom, output int n_ram,
                             output int n_io, output int n_gfx, output int n_multi,
                             output int n_unstable, output logic [31:0] rdata,
                             output logic err);
        lat = -1; n_rom = 0; n_ram = 0; n_io = 0; n_gfx = 0; n_multi = 0; n_unstable = 0;
        rdata = 32'hX; err = 1'bX;
        @(negedge clk);
        cpu_req = 1'b1; cpu_addr = addr; cpu_we = we; cpu_be = 4'hF;
        cpu_wdata = addr ^ 32'h5A5A5A5A;
        @(posedge clk); #1;
        cpu_req = 1'b0; cpu_addr = 32'hFFFFFFFF; cpu_wdata = 32'h0;
        for (int cyc = 1; cyc <= 64; cyc++) begin
            n_rom += int'(rom_sel); n_ram += int'(ram_sel);
            n_io  += int'(io_sel);  n_gfx += int'(gfx_sel);
            if ((int'(rom_sel) + int'(ram_sel) + int'(io_sel) + int'(gfx_sel)) > 1) n_multi++;
            if (bus_addr !== addr || bus_we !== we || bus_be !== 4'hF ||
                bus_wdata !== (addr ^ 32'h5A5A5A5A)) n_unstable++;
            if (cpu_ready === 1'b1) begin
                lat = cyc; rdata = cpu_rdata; err = cpu_err;
                break;
            end
            io_ack = (cyc == ack_cyc);
            @(posedge clk); #1;
        end
        io_ack = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({rom_sel, ram_sel, io_sel, gfx_sel} !== 4'b0) begin
            n_fail++; $display("FAIL reset_sel: got %b want 0000", {rom_sel, ram_sel, io_sel, gfx_sel});
        end
        n_cmp++;
        if (cpu_ready !== 1'b0 || cpu_err !== 1'b0 || cpu_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_resp: got ready=%b err=%b rdata=%h want 0/0/0",
                     cpu_ready, cpu_err, cpu_rdata);
        end
        n_cmp++;
        if (bus_addr !== 32'h0 || bus_we !== 1'b0 || bus_be !== 4'h0 || bus_wdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_bus: got %h/%b/%h/%h want all 0", bus_addr, bus_we, bus_be, bus_wdata);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_ram_read();
        int lat, nr, na, ni, ng, nm, nu; logic [31:0] rd; logic er;
        do_access(32'h08000010, 1'b0, 0, lat, nr, na, ni, ng, nm, nu, rd, er);
        n_cmp++;
        if (na !== 3 || nr + ni + ng !== 0) begin
            n_fail++; $display("FAIL ram_read_sel: got ram=%0d other=%0d want 3/0", na, nr + ni + ng);
        end
        n_cmp++;
        if (lat !== 4) begin n_fail++; $display("FAIL ram_read_latency: got %0d want 4", lat); end
        n_cmp++;
        if (rd !== 32'hDEADBEEF || er !== 1'b0) begin
            n_fail++; $display("FAIL ram_read_data: got %h err=%b want deadbeef err=0", rd, er);
        end
        n_cmp++;
        if (nu !== 0 || nm !== 0) begin
            n_fail++; $display("FAIL ram_read_bus_stable: got unstable=%0d multi=%0d want 0/0", nu, nm);
        end
    endtask

    task automatic test_io_write_ack();
        int lat, nr, na, ni, ng, nm, nu; logic [31:0] rd; logic er;
        do_access(32'h00400004, 1'b1, 3, lat, nr, na, ni, ng, nm, nu, rd, er);
        n_cmp++;
        if (ni !== 3 || lat !== 4) begin
            n_fail++; $display("FAIL io_write_ack: got io_sel=%0d lat=%0d want 3/4", ni, lat);
        end
        n_cmp++;
        if (er !== 1'b0 || rd !== 32'h0) begin
            n_fail++; $display("FAIL io_write_resp: got err=%b rdata=%h want 0/0", er, rd);
        end
    endtask

    task automatic test_io_timeout();
        int lat, nr, na, ni, ng, nm, nu; logic [31:0] rd; logic er;
        do_access(32'h00400100, 1'b0, 0, lat, nr, na, ni, ng, nm, nu, rd, er);
        n_cmp++;
        if (ni !== 16 || lat !== 17) begin
            n_fail++; $display("FAIL io_timeout_len: got io_sel=%0d lat=%0d want 16/17", ni, lat);
        end
        n_cmp++;
        if (er !== 1'b1 || rd !== 32'h0) begin
            n_fail++; $display("FAIL io_timeout_resp: got err=%b rdata=%h want 1/0", er, rd);
        end
        // Ack in the last IO_WAIT cycle beats the timeout.
        do_access(32'h00400008, 1'b0, 16, lat, nr, na, ni, ng, nm, nu, rd, er);
        n_cmp++;
        if (ni !== 16 || lat !== 17 || er !== 1'b0 || rd !== 32'h10C0FFEE) begin
            n_fail++;
            $display("FAIL io_ack_at_timeout: got sel=%0d lat=%0d err=%b rdata=%h want 16/17/0/10c0ffee",
                     ni, lat, er, rd);
        end
    endtask

    task automatic test_unmapped();
        int lat, nr, na, ni, ng, nm, nu; logic [31:0] rd; logic er;
        do_access(32'h00008000, 1'b0, 0, lat, nr, na, ni, ng, nm, nu, rd, er);
        n_cmp++;
        if (nr + na + ni + ng !== 0 || lat !== 1 || er !== 1'b1 || rd !== 32'h0) begin
            n_fail++;
            $display("FAIL unmapped: got sels=%0d lat=%0d err=%b rdata=%h want 0/1/1/0",
                     nr + na + ni + ng, lat, er, rd);
        end
    endtask

    task automatic test_decode_boundaries();
        int lat, nr, na, ni, ng, nm, nu; logic [31:0] rd; logic er;
        logic [31:0] addrs [5] = '{32'h00007FFF, 32'h0401000F, 32'h04010010,
                                   32'h0BFFFFFF, 32'h0C000000};
        // Expected {rom, ram, io, gfx} select counts, latency, err, rdata.
        int          e_cnt [5][4] = '{'{2, 0, 0, 0}, '{0, 0, 0, 2}, '{0, 0, 0, 0},
                                      '{0, 3, 0, 0}, '{0, 0, 0, 0}};
        int          e_lat [5] = '{3, 3, 1, 4, 1};
        logic        e_err [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [31:0] e_rd  [5] = '{32'h1111AAAA, 32'h6F600D00, 32'h0, 32'hDEADBEEF, 32'h0};
        for (int i = 0; i < 5; i++) begin
            do_access(addrs[i], 1'b0, 0, lat, nr, na, ni, ng, nm, nu, rd, er);
            n_cmp++;
            if (nr !== e_cnt[i][0] || na !== e_cnt[i][1] || ni !== e_cnt[i][2] ||
                ng !== e_cnt[i][3] || lat !== e_lat[i] || er !== e_err[i] || rd !== e_rd[i]) begin
                n_fail++;
                $display("FAIL decode_%h: got sel=%0d/%0d/%0d/%0d lat=%0d err=%b rd=%h want %0d/%0d/%0d/%0d lat=%0d err=%b rd=%h",
                         addrs[i], nr, na, ni, ng, lat, er, rd, e_cnt[i][0], e_cnt[i][1],
                         e_cnt[i][2], e_cnt[i][3], e_lat[i], e_err[i], e_rd[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        // ROM write with cpu_req held high and the address changed mid-access.
        int lat = -1;
        @(negedge clk);
        cpu_req = 1'b1; cpu_addr = 32'h00000040; cpu_we = 1'b1; cpu_be = 4'h3;
        cpu_wdata = 32'hCAFEF00D;
        @(posedge clk); #1;
        cpu_addr = 32'h00010000; cpu_we = 1'b0;
        for (int cyc = 1; cyc <= 16; cyc++) begin
            if (cpu_ready === 1'b1) begin lat = cyc; break; end
            @(posedge clk); #1;
        end
        n_cmp++;
        if (lat !== 3 || cpu_err !== 1'b0 || cpu_rdata !== 32'h0 || bus_addr !== 32'h00000040 ||
            bus_we !== 1'b1 || bus_be !== 4'h3 || bus_wdata !== 32'hCAFEF00D) begin
            n_fail++;
            $display("FAIL rom_write: got lat=%0d err=%b rd=%h addr=%h we=%b want 3/0/0/00000040/1",
                     lat, cpu_err, cpu_rdata, bus_addr, bus_we);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (cpu_ready !== 1'b0 || cpu_err !== 1'b0) begin
            n_fail++; $display("FAIL b2b_idle_gap: got ready=%b err=%b want 0/0", cpu_ready, cpu_err);
        end
        // Held request (now unmapped) is accepted in that IDLE cycle.
        @(posedge clk); #1;
        cpu_req = 1'b0;
        n_cmp++;
        if (cpu_ready !== 1'b1 || cpu_err !== 1'b1 || bus_addr !== 32'h00010000) begin
            n_fail++;
            $display("FAIL b2b_second: got ready=%b err=%b addr=%h want 1/1/00010000",
                     cpu_ready, cpu_err, bus_addr);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_access();
        int lat, nr, na, ni, ng, nm, nu, n_rdy; logic [31:0] rd; logic er;
        @(negedge clk);
        cpu_req = 1'b1; cpu_addr = 32'h08000020; cpu_we = 1'b0;
        @(posedge clk); #1;
        cpu_req = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (ram_sel !== 1'b1) begin
            n_fail++; $display("FAIL reset_mid_presel: got ram_sel=%b want 1", ram_sel);
        end
        reset = 1'b1;
        #1;
        n_cmp++;
        if (ram_sel !== 1'b0 || cpu_ready !== 1'b0 || bus_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_mid_abort: got ram_sel=%b ready=%b addr=%h want 0/0/0",
                     ram_sel, cpu_ready, bus_addr);
        end
        n_rdy = 0;
        repeat (3) begin
            @(posedge clk); #1;
            n_rdy += int'(cpu_ready);
        end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        n_rdy += int'(cpu_ready);
        n_cmp++;
        if (n_rdy !== 0) begin
            n_fail++; $display("FAIL reset_mid_no_ready: got %0d ready pulses want 0", n_rdy);
        end
        do_access(32'h00000100, 1'b0, 0, lat, nr, na, ni, ng, nm, nu, rd, er);
        n_cmp++;
        if (lat !== 3 || nr !== 2 || rd !== 32'h1111AAAA || er !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_rom_after: got lat=%0d sel=%0d rd=%h err=%b want 3/2/1111aaaa/0",
                     lat, nr, rd, er);
        end
    endtask

    initial begin
        test_reset();
        test_ram_read();
        test_io_write_ack();
        test_io_timeout();
        test_unmapped();
        test_decode_boundaries();
        test_back_to_back();
        test_reset_mid_access();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
